// File: rtl/game_pkg.sv
// Shared types and defaults for the score/match controller.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_KICKOFF    = 3'd1,
        S_PLAY       = 3'd2,
        S_GOAL_PAUSE = 3'd3,
        S_GAME_OVER  = 3'd4
    } game_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam int DEF_WIN_SCORE      = 7;
    localparam int DEF_KICKOFF_FRAMES = 60;
    localparam int DEF_PAUSE_FRAMES   = 120;
    localparam int DEF_FLASH_FRAMES   = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // BCD digit increment that sticks at 9 instead of wrapping.
    function automatic logic [3:0] bcd_sat_inc(input logic [3:0] s);
        return (s >= 4'd9) ? 4'd9 : s + 4'd1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: rise is high while d=1 and last sample was 0.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev <= 1'b0;
        else          prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/score_controller.sv
// Match FSM for a two-player ball game: kickoff/play/goal-pause/game-over
// sequencing, BCD score registers and scorer digit flashing.
module score_controller
    import game_pkg::*;
#(
    parameter int WIN_SCORE      = DEF_WIN_SCORE,
    parameter int KICKOFF_FRAMES = DEF_KICKOFF_FRAMES,
    parameter int PAUSE_FRAMES   = DEF_PAUSE_FRAMES,
    parameter int FLASH_FRAMES   = DEF_FLASH_FRAMES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       goal_left,
    input  logic       goal_right,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       blank_p1,
    output logic       blank_p2,
    output logic       freeze,
    output logic       ball_reset,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam int CW = $clog2(max_int(PAUSE_FRAMES, KICKOFF_FRAMES) + 1);
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    game_state_t   cur, nxt;
    logic [CW-1:0] frame_cnt;
    logic [FW-1:0] flash_cnt;
    logic          start_rise, left_rise, right_rise;
    logic          p1_goal, p2_goal, go_kick, scorer_p2;
    logic [3:0]    p1_inc, p2_inc;

    edge_detect u_start (.clk(clk), .reset_n(reset_n), .d(start_btn),  .rise(start_rise));
    edge_detect u_left  (.clk(clk), .reset_n(reset_n), .d(goal_left),  .rise(left_rise));
    edge_detect u_right (.clk(clk), .reset_n(reset_n), .d(goal_right), .rise(right_rise));

    // Simultaneous goals cancel out.
    assign p1_goal = right_rise & ~left_rise;
    assign p2_goal = left_rise & ~right_rise;
    assign p1_inc  = bcd_sat_inc(score_p1);
    assign p2_inc  = bcd_sat_inc(score_p2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= S_IDLE;
        else          cur <= nxt;
    end

    always_comb begin
        nxt     = cur;
        go_kick = 1'b0;
        case (cur)
            S_IDLE: if (start_rise) begin
                nxt     = S_KICKOFF;
                go_kick = 1'b1;
            end
            S_KICKOFF: if (frame_tick && frame_cnt == CW'(KICKOFF_FRAMES - 1)) nxt = S_PLAY;
            S_PLAY: begin
                if (p1_goal)      nxt = (p1_inc == 4'(WIN_SCORE)) ? S_GAME_OVER : S_GOAL_PAUSE;
                else if (p2_goal) nxt = (p2_inc == 4'(WIN_SCORE)) ? S_GAME_OVER : S_GOAL_PAUSE;
            end
            S_GOAL_PAUSE: if (frame_tick && frame_cnt == CW'(PAUSE_FRAMES - 1)) begin
                nxt     = S_KICKOFF;
                go_kick = 1'b1;
            end
            S_GAME_OVER: if (start_rise) begin
                nxt     = S_KICKOFF;
                go_kick = 1'b1;
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            score_p1   <= 4'd0;
            score_p2   <= 4'd0;
            blank_p1   <= 1'b0;
            blank_p2   <= 1'b0;
            ball_reset <= 1'b0;
            winner     <= WIN_NONE;
            frame_cnt  <= '0;
            flash_cnt  <= '0;
            scorer_p2  <= 1'b0;
        end else begin
            ball_reset <= go_kick;
            // A tick on the transition edge belongs to neither state.
            if (nxt != cur) begin
                frame_cnt <= '0;
                flash_cnt <= '0;
            end else if (frame_tick) begin
                if (cur == S_KICKOFF || cur == S_GOAL_PAUSE) frame_cnt <= frame_cnt + 1'b1;
                if (cur == S_GOAL_PAUSE || cur == S_GAME_OVER) begin
                    if (flash_cnt == FW'(FLASH_FRAMES - 1)) begin
                        flash_cnt <= '0;
                        if (scorer_p2) blank_p2 <= ~blank_p2;
                        else           blank_p1 <= ~blank_p1;
                    end else begin
                        flash_cnt <= flash_cnt + 1'b1;
                    end
                end
            end
            if (go_kick) begin
                blank_p1 <= 1'b0;
                blank_p2 <= 1'b0;
            end
            if (cur == S_PLAY) begin
                if (p1_goal) begin
                    score_p1  <= p1_inc;
                    scorer_p2 <= 1'b0;
                    if (p1_inc == 4'(WIN_SCORE)) winner <= WIN_P1;
                end else if (p2_goal) begin
                    score_p2  <= p2_inc;
                    scorer_p2 <= 1'b1;
                    if (p2_inc == 4'(WIN_SCORE)) winner <= WIN_P2;
                end
            end
            if (cur == S_GAME_OVER && start_rise) begin
                score_p1 <= 4'd0;
                score_p2 <= 4'd0;
                winner   <= WIN_NONE;
            end
        end
    end

    assign freeze = (cur != S_PLAY);
    assign state  = cur;

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller with a rule-level match model checked every cycle.
module tb_score_controller;
    import game_pkg::*;

    localparam int WS = 7, KF = 60, PF = 120, FF = 8;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       frame_tick = 1'b0, start_btn = 1'b0, goal_left = 1'b0, goal_right = 1'b0;
    logic [3:0] score_p1, score_p2;
    logic       blank_p1, blank_p2, freeze, ball_reset;
    logic [1:0] winner;
    logic [2:0] state;

    int n_chk = 0, n_fail = 0;
    logic run_chk = 1'b0, prev_br = 1'b0;

    score_controller #(.WIN_SCORE(WS), .KICKOFF_FRAMES(KF), .PAUSE_FRAMES(PF), .FLASH_FRAMES(FF)) dut (
        .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .start_btn(start_btn),
        .goal_left(goal_left), .goal_right(goal_right), .score_p1(score_p1), .score_p2(score_p2),
        .blank_p1(blank_p1), .blank_p2(blank_p2), .freeze(freeze), .ball_reset(ball_reset),
        .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Match model: phase, elapsed ticks in the phase, scores; flashing derived by division.
    game_state_t m_st;
    int   m_p1, m_p2, m_ticks;
    logic [1:0] m_win;
    logic m_br, m_scorer_p2, p_sb, p_gl, p_gr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_st <= S_IDLE; m_p1 <= 0; m_p2 <= 0; m_ticks <= 0; m_win <= WIN_NONE;
            m_br <= 1'b0; m_scorer_p2 <= 1'b0; p_sb <= 1'b0; p_gl <= 1'b0; p_gr <= 1'b0;
        end else begin : mdl
            game_state_t st;
            int p1, p2, t, s;
            logic [1:0] w;
            logic br, sc, rs, rl, rr;
            st = m_st; p1 = m_p1; p2 = m_p2; t = m_ticks; w = m_win; sc = m_scorer_p2; br = 1'b0;
            rs = start_btn & ~p_sb; rl = goal_left & ~p_gl; rr = goal_right & ~p_gr;
            case (st)
                S_IDLE: if (rs) begin st = S_KICKOFF; br = 1'b1; t = 0; end
                S_KICKOFF: if (frame_tick) begin
                    t = t + 1;
                    if (t == KF) begin st = S_PLAY; t = 0; end
                end
                S_PLAY: if (rl != rr) begin
                    sc = rl;
                    if (rr) begin p1 = (p1 + 1 > 9) ? 9 : p1 + 1; s = p1; end
                    else    begin p2 = (p2 + 1 > 9) ? 9 : p2 + 1; s = p2; end
                    t = 0;
                    if (s == WS) begin st = S_GAME_OVER; w = rr ? WIN_P1 : WIN_P2; end
                    else st = S_GOAL_PAUSE;
                end
                S_GOAL_PAUSE: if (frame_tick) begin
                    t = t + 1;
                    if (t == PF) begin st = S_KICKOFF; br = 1'b1; t = 0; end
                end
                default: begin
                    if (rs) begin st = S_KICKOFF; br = 1'b1; t = 0; p1 = 0; p2 = 0; w = WIN_NONE; end
                    else if (frame_tick) t = t + 1;
                end
            endcase
            m_st <= st; m_p1 <= p1; m_p2 <= p2; m_ticks <= t; m_win <= w;
            m_br <= br; m_scorer_p2 <= sc;
            p_sb <= start_btn; p_gl <= goal_left; p_gr <= goal_right;
        end
    end

    always @(negedge clk) begin
        if (reset_n && run_chk) begin : cmp
            logic fl;
            fl = (m_st == S_GOAL_PAUSE || m_st == S_GAME_OVER) && ((m_ticks / FF) % 2 == 1);
            chk("m_state",      32'(state),      32'(m_st));
            chk("m_score_p1",   32'(score_p1),   32'(m_p1));
            chk("m_score_p2",   32'(score_p2),   32'(m_p2));
            chk("m_blank_p1",   32'(blank_p1),   32'(fl & ~m_scorer_p2));
            chk("m_blank_p2",   32'(blank_p2),   32'(fl & m_scorer_p2));
            chk("m_freeze",     32'(freeze),     32'(m_st != S_PLAY));
            chk("m_ball_reset", 32'(ball_reset), 32'(m_br));
            chk("m_winner",     32'(winner),     32'(m_win));
            chk("br_twice",     32'(ball_reset & prev_br), 32'd0);
        end
        prev_br <= ball_reset;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk) frame_tick = 1'b1;
            @(negedge clk) frame_tick = 1'b0;
        end
    endtask

    initial begin
        cyc(3);
        chk("rst_state",  32'(state), 32'(S_IDLE));
        chk("rst_freeze", 32'(freeze), 32'd1);
        chk("rst_scores", 32'({score_p1, score_p2}), 32'd0);
        chk("rst_br",     32'(ball_reset), 32'd0);
        reset_n = 1'b1;
        run_chk = 1'b1;
        cyc(2);

        // start -> kickoff -> play after exactly 60 ticks
        start_btn = 1'b1;
        cyc(1);
        chk("start_br",    32'(ball_reset), 32'd1);
        chk("start_state", 32'(state), 32'(S_KICKOFF));
        start_btn = 1'b0;
        cyc(1);
        chk("start_br_off", 32'(ball_reset), 32'd0);
        tick_n(59);
        chk("kick_59", 32'(state), 32'(S_KICKOFF));
        chk("kick_59_freeze", 32'(freeze), 32'd1);
        tick_n(1);
        chk("kick_60", 32'(state), 32'(S_PLAY));
        chk("play_freeze", 32'(freeze), 32'd0);

        // goal_right held 5 cycles scores once; flash and pause timing
        goal_right = 1'b1;
        cyc(5);
        goal_right = 1'b0;
        chk("gr_score_p1", 32'(score_p1), 32'd1);
        chk("gr_state", 32'(state), 32'(S_GOAL_PAUSE));
        chk("flash_0", 32'(blank_p1), 32'd0);
        tick_n(8);
        chk("flash_8", 32'(blank_p1), 32'd1);
        tick_n(8);
        chk("flash_16", 32'(blank_p1), 32'd0);
        tick_n(103);
        chk("pause_119", 32'(state), 32'(S_GOAL_PAUSE));
        tick_n(1);
        chk("pause_120", 32'(state), 32'(S_KICKOFF));
        chk("pause_br", 32'(ball_reset), 32'd1);
        chk("pause_blank", 32'(blank_p1), 32'd0);
        tick_n(KF);

        // simultaneous goals ignored
        goal_left = 1'b1; goal_right = 1'b1;
        cyc(2);
        chk("both_scores", 32'({score_p1, score_p2}), 32'h10);
        chk("both_state", 32'(state), 32'(S_PLAY));
        goal_left = 1'b0; goal_right = 1'b0;
        cyc(1);

        // goal_left held through pause into play: no extra score
        goal_left = 1'b1;
        cyc(1);
        chk("gl_score_p2", 32'(score_p2), 32'd1);
        tick_n(PF + KF);
        cyc(3);
        chk("held_score_p2", 32'(score_p2), 32'd1);
        chk("held_state", 32'(state), 32'(S_PLAY));
        goal_left = 1'b0;
        cyc(1);
        goal_left = 1'b1;
        cyc(1);
        chk("rerise_p2", 32'(score_p2), 32'd2);
        goal_left = 1'b0;
        tick_n(PF + KF);

        // P2 runs to 7
        for (int k = 3; k <= WS; k++) begin
            goal_left = 1'b1;
            cyc(1);
            goal_left = 1'b0;
            if (k < WS) tick_n(PF + KF);
        end
        chk("go_p2", 32'(score_p2), 32'd7);
        chk("go_state", 32'(state), 32'(S_GAME_OVER));
        chk("go_winner", 32'(winner), 32'(WIN_P2));
        chk("go_freeze", 32'(freeze), 32'd1);
        cyc(1);
        goal_left = 1'b1;
        cyc(1);
        goal_left = 1'b0;
        cyc(1);
        chk("go_extra_p2", 32'(score_p2), 32'd7);
        tick_n(8);
        chk("go_flash", 32'(blank_p2), 32'd1);
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
        chk("restart_scores", 32'({score_p1, score_p2}), 32'd0);
        chk("restart_state", 32'(state), 32'(S_KICKOFF));
        chk("restart_winner", 32'(winner), 32'd0);
        chk("restart_blank", 32'(blank_p2), 32'd0);

        // async reset in the middle of a goal pause
        tick_n(KF);
        goal_right = 1'b1;
        cyc(1);
        goal_right = 1'b0;
        tick_n(10);
        chk("pre_rst_blank", 32'(blank_p1), 32'd1);
        #2 reset_n = 1'b0;
        goal_right = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'(S_IDLE));
        chk("arst_blank", 32'({blank_p1, blank_p2}), 32'd0);
        chk("arst_scores", 32'({score_p1, score_p2}), 32'd0);
        chk("arst_freeze", 32'(freeze), 32'd1);
        cyc(2);
        reset_n = 1'b1;
        cyc(3);
        chk("post_rst_p1", 32'(score_p1), 32'd0);
        chk("post_rst_state", 32'(state), 32'(S_IDLE));
        goal_right = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
